// File: rtl/vfx_pkg.sv
// Shared video-effects definitions: filter selection codes, default channel width,
// pixel layout and the frame-tracking states used by the filter consumer.
package vfx_pkg;

  localparam int CH_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    FLT_PASS   = 2'd0,
    FLT_GREY   = 2'd1,
    FLT_INVERT = 2'd2,
    FLT_RED    = 2'd3
  } filter_t;

  typedef struct packed {
    logic [CH_W_DEFAULT-1:0] r;
    logic [CH_W_DEFAULT-1:0] g;
    logic [CH_W_DEFAULT-1:0] b;
  } pixel_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } frame_state_t;

endpackage

// File: rtl/pixel_effect.sv
// Combinational per-pixel effect: pass, luma-style grey, channel invert or red-only.
module pixel_effect
  import vfx_pkg::*;
#(
  parameter int CH_W = CH_W_DEFAULT
) (
  input  filter_t           sel,
  input  logic [3*CH_W-1:0] pix_in,
  output logic [3*CH_W-1:0] pix_out
);

  localparam logic [CH_W-1:0] CH_MAX = '1;

  logic [CH_W-1:0]   r;
  logic [CH_W-1:0]   g;
  logic [CH_W-1:0]   b;
  logic [CH_W+1:0]   sum;
  logic [CH_W-1:0]   y;
  logic [3*CH_W-1:0] inv;

  assign r = pix_in[3*CH_W-1 -: CH_W];
  assign g = pix_in[2*CH_W-1 -: CH_W];
  assign b = pix_in[CH_W-1:0];

  // R + 2G + B peaks at 4*(2^CH_W - 1), so CH_W+2 bits never overflow
  assign sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
  assign y   = CH_W'(sum >> 2);

  for (genvar gi = 0; gi < 3; gi++) begin : g_inv
    assign inv[gi*CH_W +: CH_W] = CH_MAX - pix_in[gi*CH_W +: CH_W];
  end

  always_comb begin
    pix_out = pix_in;
    case (sel)
      FLT_PASS:   pix_out = pix_in;
      FLT_GREY:   pix_out = {y, y, y};
      FLT_INVERT: pix_out = inv;
      FLT_RED:    pix_out = {r, {(2*CH_W){1'b0}}};
      default:    pix_out = pix_in;
    endcase
  end

endmodule

// File: rtl/filter_apply.sv
// Applies the requested effect to a valid/ready pixel stream, switching effect only at SOP.
// One output register plus a one-entry skid buffer keep s_ready free of any m_ready path.
module filter_apply
  import vfx_pkg::*;
#(
  parameter  int CH_W  = CH_W_DEFAULT,
  localparam int PIX_W = 3 * CH_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       filter_type,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_sop,
  input  logic             s_eop,
  output logic             s_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_valid,
  output logic             m_sop,
  output logic             m_eop,
  input  logic             m_ready,
  output logic [1:0]       active_filter,
  output logic             filter_chg,
  output logic             frame_err
);

  localparam int BEAT_W = PIX_W + 2;

  frame_state_t      state_reg;
  frame_state_t      state_next;
  filter_t           active_reg;
  filter_t           req_filter;
  filter_t           eff_sel;
  logic              chg_reg;
  logic              err_reg;
  logic              out_valid_reg;
  logic [BEAT_W-1:0] out_beat_reg;
  logic              skid_valid_reg;
  logic [BEAT_W-1:0] skid_beat_reg;

  logic              accept;
  logic              forward;
  logic              latch;
  logic              err_set;
  logic              out_free;
  logic [PIX_W-1:0]  eff_pix;
  logic [BEAT_W-1:0] new_beat;

  assign req_filter = filter_t'(filter_type);
  assign s_ready    = !skid_valid_reg;
  assign accept     = s_valid && s_ready;
  assign out_free   = !out_valid_reg || m_ready;

  // The SOP beat already belongs to the new frame, so it uses the requested effect directly
  assign eff_sel = s_sop ? req_filter : active_reg;

  pixel_effect #(
    .CH_W (CH_W)
  ) u_effect (
    .sel     (eff_sel),
    .pix_in  (s_data),
    .pix_out (eff_pix)
  );

  assign new_beat = {eff_pix, s_sop, s_eop};

  always_comb begin
    state_next = state_reg;
    forward    = 1'b0;
    latch      = 1'b0;
    err_set    = 1'b0;
    if (accept) begin
      case (state_reg)
        ST_IDLE: begin
          if (s_sop) begin
            forward    = 1'b1;
            latch      = 1'b1;
            state_next = s_eop ? ST_IDLE : ST_IN_FRAME;
          end else begin
            err_set = 1'b1;
          end
        end
        ST_IN_FRAME: begin
          forward = 1'b1;
          if (s_sop) begin
            latch   = 1'b1;
            err_set = 1'b1;
          end
          if (s_eop) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_reg <= FLT_PASS;
      chg_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      chg_reg <= latch && (req_filter != active_reg);
      if (latch) begin
        active_reg <= req_filter;
      end
      if (err_set) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Skid buffer only fills when a beat is accepted while the output register is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      out_beat_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_beat_reg  <= '0;
    end else if (out_free) begin
      if (skid_valid_reg) begin
        out_valid_reg  <= 1'b1;
        out_beat_reg   <= skid_beat_reg;
        skid_valid_reg <= 1'b0;
      end else begin
        out_valid_reg <= forward;
        if (forward) begin
          out_beat_reg <= new_beat;
        end
      end
    end else if (forward) begin
      skid_valid_reg <= 1'b1;
      skid_beat_reg  <= new_beat;
    end
  end

  assign m_valid       = out_valid_reg;
  assign m_data        = out_beat_reg[BEAT_W-1:2];
  assign m_sop         = out_beat_reg[1];
  assign m_eop         = out_beat_reg[0];
  assign active_filter = active_reg;
  assign filter_chg    = chg_reg;
  assign frame_err     = err_reg;

endmodule

// File: tb/tb_filter_apply.sv
// Directed bench for filter_apply: effects, SOP-aligned filter switching, backpressure,
// protocol errors and mid-frame reset, checked against hand-computed beats.
module tb_filter_apply;

  localparam int CH_W  = 4;
  localparam int PIX_W = 12;

  typedef logic [PIX_W+1:0] beat_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       filter_type;
  logic [PIX_W-1:0] s_data;
  logic             s_valid;
  logic             s_sop;
  logic             s_eop;
  logic             s_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_valid;
  logic             m_sop;
  logic             m_eop;
  logic             m_ready;
  logic [1:0]       active_filter;
  logic             filter_chg;
  logic             frame_err;

  int    checks   = 0;
  int    failures = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  bit    bp_en      = 1'b0;
  bit    stall_prev = 1'b0;
  beat_t held;

  always #5 clk = ~clk;

  filter_apply #(
    .CH_W (CH_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .filter_type   (filter_type),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_sop         (s_sop),
    .s_eop         (s_eop),
    .s_ready       (s_ready),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_sop         (m_sop),
    .m_eop         (m_eop),
    .m_ready       (m_ready),
    .active_filter (active_filter),
    .filter_chg    (filter_chg),
    .frame_err     (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [11:0] model(input int ft, input logic [11:0] p);
    int r, g, b, y;
    r = int'(p[11:8]);
    g = int'(p[7:4]);
    b = int'(p[3:0]);
    case (ft)
      1: begin
        y = (r + 2 * g + b) / 4;
        return {y[3:0], y[3:0], y[3:0]};
      end
      2: return {4'(15 - r), 4'(15 - g), 4'(15 - b)};
      3: return {p[11:8], 8'h00};
      default: return p;
    endcase
  endfunction

  // Output monitor and stall-stability check, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_hold", 32'({m_data, m_sop, m_eop}), 32'(held));
      end
      if (m_valid && m_ready) got_q.push_back({m_data, m_sop, m_eop});
      stall_prev = m_valid && !m_ready;
      held       = {m_data, m_sop, m_eop};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted
  task automatic send(input logic [11:0] d, input bit sop, input bit eop);
    int n = 0;
    s_data  = d;
    s_sop   = sop;
    s_eop   = eop;
    s_valid = 1'b1;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    if (!s_ready) check("s_ready_wait", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    s_sop   = 1'b0;
    s_eop   = 1'b0;
  endtask

  task automatic expect_beat(input logic [11:0] d, input bit sop, input bit eop);
    exp_q.push_back({d, sop, eop});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 500) begin
      tick();
      n++;
    end
    tick();
    tick();
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    logic [11:0] d;
    reset       = 1'b1;
    filter_type = 2'd0;
    s_data      = '0;
    s_valid     = 1'b0;
    s_sop       = 1'b0;
    s_eop       = 1'b0;
    m_ready     = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'({m_data, m_sop, m_eop}), 32'd0);
    check("rst_active", 32'(active_filter), 32'd0);
    check("rst_chg", 32'(filter_chg), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);

    // Pass-through frame, one-cycle latency
    filter_type = 2'd0;
    send(12'hABC, 1, 0);
    check("lat_m_valid", 32'(m_valid), 32'd1);
    check("lat_m_data", 32'(m_data), 32'hABC);
    check("pass_chg", 32'(filter_chg), 32'd0);
    send(12'h123, 0, 0);
    send(12'h456, 0, 0);
    send(12'h789, 0, 1);
    expect_beat(12'hABC, 1, 0);
    expect_beat(12'h123, 0, 0);
    expect_beat(12'h456, 0, 0);
    expect_beat(12'h789, 0, 1);
    drain("pass");

    // Grey on a one-pixel frame: (4 + 24 + 8) >> 2 = 9
    filter_type = 2'd1;
    send(12'h4C8, 1, 1);
    check("grey_chg_pulse", 32'(filter_chg), 32'd1);
    check("grey_active", 32'(active_filter), 32'd1);
    tick();
    check("grey_chg_clear", 32'(filter_chg), 32'd0);
    expect_beat(12'h999, 1, 1);
    filter_type = 2'd2;
    send(12'h0F3, 1, 1);
    expect_beat(12'hF0C, 1, 1);
    filter_type = 2'd3;
    send(12'hABC, 1, 1);
    expect_beat(12'hA00, 1, 1);
    drain("effects");

    // Switch request mid-frame: takes effect only on the next SOP
    filter_type = 2'd2;
    send(12'h0F3, 1, 0);
    check("sw_chg_sop", 32'(filter_chg), 32'd1);
    filter_type = 2'd3;
    send(12'h123, 0, 0);
    check("sw_active_mid", 32'(active_filter), 32'd2);
    check("sw_chg_mid", 32'(filter_chg), 32'd0);
    send(12'h800, 0, 1);
    send(12'h456, 1, 0);
    check("sw_chg_next", 32'(filter_chg), 32'd1);
    check("sw_active_next", 32'(active_filter), 32'd3);
    send(12'h9AB, 0, 1);
    check("sw_chg_single", 32'(filter_chg), 32'd0);
    expect_beat(12'hF0C, 1, 0);
    expect_beat(12'hEDC, 0, 0);
    expect_beat(12'h7FF, 0, 1);
    expect_beat(12'h400, 1, 0);
    expect_beat(12'h900, 0, 1);
    drain("switch");

    // 64-pixel grey frame under random backpressure
    filter_type = 2'd1;
    bp_en       = 1'b1;
    for (int i = 0; i < 64; i++) begin
      d = 12'($urandom);
      send(d, i == 0, i == 63);
      expect_beat(model(1, d), i == 0, i == 63);
    end
    drain("bp");
    bp_en = 1'b0;
    tick();
    m_ready = 1'b1;
    tick();

    // Protocol errors: beat without SOP dropped, SOP mid-frame relatches
    filter_type = 2'd0;
    send(12'h777, 0, 0);
    check("drop_err", 32'(frame_err), 32'd1);
    send(12'hAAA, 1, 0);
    filter_type = 2'd1;
    send(12'h4C8, 1, 0);
    check("resop_err", 32'(frame_err), 32'd1);
    check("resop_active", 32'(active_filter), 32'd1);
    check("resop_chg", 32'(filter_chg), 32'd1);
    expect_beat(12'hAAA, 1, 0);
    expect_beat(12'h999, 1, 0);
    drain("err");

    // Reset mid-frame discards the in-flight beat
    filter_type = 2'd2;
    send(12'h222, 0, 0);
    reset = 1'b1;
    tick();
    check("mrst_m_valid", 32'(m_valid), 32'd0);
    check("mrst_active", 32'(active_filter), 32'd0);
    check("mrst_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    tick();
    check("mrst_s_ready", 32'(s_ready), 32'd1);
    filter_type = 2'd0;
    send(12'h5A5, 1, 1);
    expect_beat(12'h5A5, 1, 1);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
